// File: rtl/adc_sample_capture.sv
// ADC sample capture: selects one lane of a multi-sample AXI-Stream beat, provides a
// registered live value, and on run averages 2^n selected samples after a beat delay.
module adc_sample_capture #(
  parameter int NUM_BITS     = 16,
  parameter int SPC          = 8,
  parameter int MAX_AVG_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPC*NUM_BITS-1:0]   adc_tdata,
  input  logic                      adc_tvalid,
  output logic                      adc_tready,
  input  logic [$clog2(SPC)-1:0]    cfg_sample_idx,
  input  logic [15:0]               cfg_delay,
  input  logic [3:0]                cfg_avg_log2,
  input  logic                      run,
  output logic [NUM_BITS-1:0]       live_val,
  output logic                      live_valid,
  output logic [NUM_BITS-1:0]       val_out,
  output logic                      val_valid,
  output logic                      busy,
  output logic                      run_overrun
);

  // state  | meaning
  // IDLE   | waiting for run
  // DELAY  | skipping cfg_delay valid beats
  // ACCUM  | summing 2^n valid beats of the latched lane
  // OUT    | result strobe cycle; run here counts as overrun
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int IDX_W = $clog2(SPC);
  localparam int ACC_W = NUM_BITS + MAX_AVG_LOG2;
  localparam int CNT_W = (MAX_AVG_LOG2 + 1 > 16) ? MAX_AVG_LOG2 + 1 : 16;
  localparam logic [3:0]       MAX_N   = 4'(MAX_AVG_LOG2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx_q;
  logic [3:0]                n_q;
  logic [3:0]                n_cfg;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          pow_cfg;
  logic [CNT_W-1:0]          pow_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic [NUM_BITS-1:0]       lane_live;
  logic [NUM_BITS-1:0]       lane_cap;

  assign adc_tready = ~rst;
  assign busy       = (state != S_IDLE);

  assign n_cfg     = (cfg_avg_log2 > MAX_N) ? MAX_N : cfg_avg_log2;
  assign pow_cfg   = CNT_ONE << n_cfg;
  assign pow_q     = CNT_ONE << n_q;
  assign lane_live = adc_tdata[cfg_sample_idx*NUM_BITS +: NUM_BITS];
  assign lane_cap  = adc_tdata[idx_q*NUM_BITS +: NUM_BITS];
  assign acc_next  = acc + {{MAX_AVG_LOG2{lane_cap[NUM_BITS-1]}}, lane_cap};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      cnt         <= '0;
      acc         <= '0;
      live_val    <= '0;
      live_valid  <= 1'b0;
      val_out     <= '0;
      val_valid   <= 1'b0;
      run_overrun <= 1'b0;
    end else begin
      if (adc_tvalid) begin
        live_val   <= lane_live;
        live_valid <= 1'b1;
      end else begin
        live_valid <= 1'b0;
      end

      val_valid <= 1'b0;
      if (run && state != S_IDLE) run_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (run) begin
            idx_q <= cfg_sample_idx;
            n_q   <= n_cfg;
            acc   <= '0;
            if (cfg_delay != 16'd0) begin
              cnt   <= CNT_W'(cfg_delay);
              state <= S_DELAY;
            end else begin
              cnt   <= pow_cfg;
              state <= S_ACCUM;
            end
          end
        end
        S_DELAY: begin
          if (adc_tvalid) begin
            if (cnt == CNT_ONE) begin
              cnt   <= pow_q;
              state <= S_ACCUM;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        S_ACCUM: begin
          if (adc_tvalid) begin
            acc <= acc_next;
            cnt <= cnt - CNT_ONE;
            // Result registered on the final beat so it is visible during OUT.
            if (cnt == CNT_ONE) begin
              val_out   <= NUM_BITS'(acc_next >>> n_q);
              val_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
